// File: rtl/fifo_w1_r16_pkg.sv
// Shared sizing and count helper for the 1-bit-in / 16-bit-out FIFO.
package fifo_w1_r16_pkg;

    localparam int WORD_W      = 16;
    localparam int DEPTH_WORDS = 64;
    localparam int ADDR_W      = $clog2(DEPTH_WORDS);
    localparam int CNT_W       = ADDR_W + 1;
    localparam int BIT_CNT_W   = $clog2(WORD_W);

    // Occupancy after one cycle; a simultaneous push and pop cancel out.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                     input logic             push,
                                                     input logic             pop);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (push && !pop) res = cnt + CNT_W'(1);
        else if (pop && !push) res = cnt - CNT_W'(1);
        return res;
    endfunction

endpackage

// File: rtl/fifo_w1_r16_1024_sync_if.sv
// Host-side bus of the width-converting FIFO; rd_data_count exists only with FIFO_W1_R16_COUNT_EN.
interface fifo_w1_r16_1024_sync_if;
    import fifo_w1_r16_pkg::*;

    logic              din;
    logic              wr_en;
    logic              rd_en;
    logic [WORD_W-1:0] dout;
    logic              full;
    logic              empty;
`ifdef FIFO_W1_R16_COUNT_EN
    logic [ADDR_W:0]   rd_data_count;
`endif

    modport master (
        output din, wr_en, rd_en,
`ifdef FIFO_W1_R16_COUNT_EN
        input  rd_data_count,
`endif
        input  dout, full, empty
    );

    modport slave (
        input  din, wr_en, rd_en,
`ifdef FIFO_W1_R16_COUNT_EN
        output rd_data_count,
`endif
        output dout, full, empty
    );

endinterface

// File: rtl/fifo_w1_r16_1024_sync_bit_packer_16.sv
// Serial-in/parallel-out packer: gathers 16 bits MSB-first and flags the completed word
// combinationally so it can be stored on the same edge as the last bit.
module bit_packer_16
    import fifo_w1_r16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_vld,
    input  logic              din,
    output logic              word_vld,
    output logic [WORD_W-1:0] word
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0]    sr_p0;
    logic [BIT_CNT_W-1:0] bit_cnt_p0;

    // stage p0: shift register and bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_p0      <= '0;
            bit_cnt_p0 <= '0;
        end else if (bit_vld) begin
            sr_p0      <= {sr_p0[WORD_W-2:0], din};
            bit_cnt_p0 <= bit_cnt_p0 + BIT_CNT_W'(1);
        end
    end

    assign word_vld = bit_vld && (bit_cnt_p0 == LAST_BIT);
    assign word     = {sr_p0[WORD_W-2:0], din};

endmodule

// File: rtl/fifo_w1_r16_1024_sync.sv
// Single-clock FIFO: 1-bit serial writes packed MSB-first into 64 x 16-bit words, 16-bit reads.
// Optional rd_data_count output under `FIFO_W1_R16_COUNT_EN.
module fifo_w1_r16_1024_sync
    import fifo_w1_r16_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_w1_r16_1024_sync_if.slave  bus
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_q;
    logic              empty_q;
    logic [WORD_W-1:0] dout_p1;

    logic              bit_vld;
    logic              pop;
    logic              vld_p0;
    logic [WORD_W-1:0] word_p0;

    // A full FIFO refuses bits outright, so a word push never lands on an occupied slot.
    assign bit_vld = bus.wr_en && !full_q;
    assign pop     = bus.rd_en && !empty_q;

    bit_packer_16 u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_vld  (bit_vld),
        .din      (bus.din),
        .word_vld (vld_p0),
        .word     (word_p0)
    );

    assign count_nxt = next_count(count, vld_p0, pop);

    // stage p0 -> storage: word array carries no reset
    always_ff @(posedge clk) begin
        if (vld_p0) mem[wr_ptr] <= word_p0;
    end

    // stage p1: pointers, occupancy, flags and read register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            dout_p1 <= '0;
        end else begin
            if (vld_p0) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                dout_p1 <= mem[rd_ptr];
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(DEPTH_WORDS));
            empty_q <= (count_nxt == '0);
        end
    end

    assign bus.dout  = dout_p1;
    assign bus.full  = full_q;
    assign bus.empty = empty_q;
`ifdef FIFO_W1_R16_COUNT_EN
    assign bus.rd_data_count = count;
`endif

endmodule

// File: tb/tb_fifo_w1_r16_1024_sync.sv
// Directed bench for fifo_w1_r16_1024_sync: reset, packing, streaming, partial words,
// fill/overflow, pointer wrap and mid-word reset.
module tb_fifo_w1_r16_1024_sync;
    import fifo_w1_r16_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    fifo_w1_r16_1024_sync_if bus ();

    fifo_w1_r16_1024_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bit(input logic b);
        bus.din   = b;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) write_bit(w[i]);
    endtask

    task automatic read_word();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] stream;
        logic [15:0] w;

        rst_n     = 1'b0;
        bus.din   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        // 1. reset
        repeat (5) tick();
        check("rst_dout", bus.dout, 16'h0000);
        check("rst_empty", {15'd0, bus.empty}, 16'd1);
        check("rst_full", {15'd0, bus.full}, 16'd0);
`ifdef FIFO_W1_R16_COUNT_EN
        check("rst_count", {9'd0, bus.rd_data_count}, 16'd0);
`endif
        rst_n = 1'b1;
        tick();
        read_word();
        read_word();
        check("empty_read_dout", bus.dout, 16'h0000);
        check("empty_read_empty", {15'd0, bus.empty}, 16'd1);

        // 2. single word
        w = 16'hAAF0;
        for (int i = 15; i >= 1; i--) write_bit(w[i]);
        check("single_15_empty", {15'd0, bus.empty}, 16'd1);
        write_bit(w[0]);
        check("single_16_empty", {15'd0, bus.empty}, 16'd0);
`ifdef FIFO_W1_R16_COUNT_EN
        check("single_count", {9'd0, bus.rd_data_count}, 16'd1);
`endif
        read_word();
        check("single_dout", bus.dout, 16'hAAF0);
        check("single_empty_after", {15'd0, bus.empty}, 16'd1);

        // 3. streaming with rd_en held high
        stream    = 32'hAAF0_550F;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.din   = stream[31-i];
            bus.wr_en = 1'b1;
            tick();
            if (i == 15) check("stream_w0_dout_before", bus.dout, 16'hAAF0);
            if (i == 16) check("stream_w0_dout", bus.dout, 16'hAAF0);
            if (i == 30) check("stream_hold_dout", bus.dout, 16'hAAF0);
            if (i == 31) check("stream_w1_empty", {15'd0, bus.empty}, 16'd0);
        end
        bus.wr_en = 1'b0;
        tick();
        check("stream_w1_dout", bus.dout, 16'h550F);
        check("stream_empty_end", {15'd0, bus.empty}, 16'd1);
        tick();
        bus.rd_en = 1'b0;
        check("stream_no_dup", bus.dout, 16'h550F);

        // 4. partial word
        w = 16'h1234;
        for (int i = 15; i >= 1; i--) write_bit(w[i]);
        check("partial_empty", {15'd0, bus.empty}, 16'd1);
        read_word();
        check("partial_read_dout", bus.dout, 16'h550F);
        write_bit(w[0]);
        check("partial_16_empty", {15'd0, bus.empty}, 16'd0);
        read_word();
        check("partial_word", bus.dout, 16'h1234);

        // 5. fill, overflow, simultaneous read+write while full
        for (int k = 0; k < 64; k++) begin
            write_word(16'(k));
            if (k == 62) check("fill_63_full", {15'd0, bus.full}, 16'd0);
        end
        check("fill_64_full", {15'd0, bus.full}, 16'd1);
`ifdef FIFO_W1_R16_COUNT_EN
        check("fill_count", {9'd0, bus.rd_data_count}, 16'd64);
`endif
        write_word(16'hFFFF);
        check("overflow_full", {15'd0, bus.full}, 16'd1);
        bus.din   = 1'b1;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("full_rw_dout", bus.dout, 16'h0000);
        check("full_rw_full", {15'd0, bus.full}, 16'd0);
        for (int k = 1; k < 64; k++) begin
            read_word();
            check($sformatf("drain_%0d", k), bus.dout, 16'(k));
        end
        check("drain_empty", {15'd0, bus.empty}, 16'd1);
        write_word(16'hBEEF);
        read_word();
        check("post_overflow_word", bus.dout, 16'hBEEF);

        // 6. wrap pointers, then reset mid-word
        for (int k = 0; k < 100; k++) begin
            w = 16'(k * 16'h0101) ^ 16'h5A3C;
            write_word(w);
            read_word();
            check($sformatf("wrap_%0d", k), bus.dout, w);
        end
        write_word(16'h1111);
        for (int i = 0; i < 8; i++) write_bit(1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_empty", {15'd0, bus.empty}, 16'd1);
        check("midrst_full", {15'd0, bus.full}, 16'd0);
        check("midrst_dout", bus.dout, 16'h0000);
        w = 16'hC3A5;
        for (int i = 15; i >= 1; i--) write_bit(w[i]);
        check("fresh_15_empty", {15'd0, bus.empty}, 16'd1);
        write_bit(w[0]);
        check("fresh_16_empty", {15'd0, bus.empty}, 16'd0);
        read_word();
        check("fresh_word", bus.dout, 16'hC3A5);
        check("fresh_empty_after", {15'd0, bus.empty}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
